// File: rtl/configurable_cache_pkg.sv
// Shared constants and helpers for the sectored set-associative cache model.
// Holds clog2/is_pow2 and the default geometry with its derived address-field widths.
package configurable_cache_pkg;

  localparam int ADDR_W = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while (r < 31 && (1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  localparam int DEF_CACHE_SIZE = 8192;
  localparam int DEF_LINE_SIZE  = 32;
  localparam int DEF_SECTOR_SIZE = 4;
  localparam int DEF_ASSOC      = 32;

  localparam int DEF_SPL      = DEF_LINE_SIZE / DEF_SECTOR_SIZE;
  localparam int DEF_NUM_SETS =
    DEF_CACHE_SIZE / (DEF_LINE_SIZE * DEF_ASSOC);

  localparam int DEF_BYTE_W = clog2(DEF_SECTOR_SIZE);
  localparam int DEF_SEC_W  = clog2(DEF_SPL);
  localparam int DEF_OFF_W  = clog2(DEF_LINE_SIZE);
  localparam int DEF_SET_W  = clog2(DEF_NUM_SETS);
  localparam int DEF_TAG_W  = ADDR_W - DEF_SET_W - DEF_OFF_W;

endpackage

// File: rtl/configurable_cache_lru.sv
// Per-set true-LRU ages: 0 = MRU, WAYS-1 = LRU; reset ages equal way index.
// Ports: clk, rst (sync, active-low), set_idx, update, way (accessed), victim (LRU way of set_idx).
module configurable_cache_lru
  import configurable_cache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int WAYS     = 32,
  parameter int SET_IW   = 3,
  parameter int WAY_IW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SET_IW-1:0] set_idx,
  input  logic              update,
  input  logic [WAY_IW-1:0] way,
  output logic [WAY_IW-1:0] victim
);

  logic [WAY_IW-1:0] ages [NUM_SETS][WAYS];
  logic [WAY_IW-1:0] cur;

  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages[set_idx][w] == WAY_IW'(WAYS - 1))
        victim = WAY_IW'(w);
    end
  end

  assign cur = ages[set_idx][way];

  // Accessed way drops to age 0; only ways younger than it age by one,
  // so each set's ages stay a permutation of 0..WAYS-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < WAYS; w++)
          ages[s][w] <= WAY_IW'(w);
    end else if (update) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_IW'(w) == way)
          ages[set_idx][w] <= '0;
        else if (ages[set_idx][w] < cur)
          ages[set_idx][w] <= ages[set_idx][w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/configurable_cache.sv
// Sectored set-associative hit/miss model (tags and sector valids only, no data).
// Ports: clk, rst (sync, active-low), addr; registered hit/miss, hit/miss counters, geometry constants.
module configurable_cache
  import configurable_cache_pkg::*;
#(
  parameter int CACHE_SIZE    = DEF_CACHE_SIZE,
  parameter int LINE_SIZE     = DEF_LINE_SIZE,
  parameter int SECTOR_SIZE   = DEF_SECTOR_SIZE,
  parameter int ASSOCIATIVITY = DEF_ASSOC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic              miss,
  output logic [31:0]       total_hits,
  output logic [31:0]       total_misses,
  output logic [31:0]       sectors_per_line,
  output logic [31:0]       num_sets,
  output logic [31:0]       tag_bits
);

  localparam int SPL      = LINE_SIZE / SECTOR_SIZE;
  localparam int NSETS    = CACHE_SIZE / (LINE_SIZE * ASSOCIATIVITY);
  localparam int NSETS_I  = max1(NSETS);
  localparam int WAYS     = ASSOCIATIVITY;
  localparam int BYTE_W   = clog2(SECTOR_SIZE);
  localparam int SEC_W    = clog2(SPL);
  localparam int OFF_W    = clog2(LINE_SIZE);
  localparam int SET_W    = clog2(NSETS_I);
  localparam int TAG_W    = ADDR_W - SET_W - OFF_W;
  localparam int WAY_W    = clog2(WAYS);
  localparam int SEC_IW   = max1(SEC_W);
  localparam int SET_IW   = max1(SET_W);
  localparam int WAY_IW   = max1(WAY_W);

  if (!is_pow2(CACHE_SIZE) || !is_pow2(LINE_SIZE) ||
      !is_pow2(SECTOR_SIZE) || !is_pow2(ASSOCIATIVITY) ||
      SECTOR_SIZE > LINE_SIZE || NSETS < 1) begin : g_bad_cfg
    $error("configurable_cache: illegal geometry");
  end

  assign sectors_per_line = 32'(SPL);
  assign num_sets         = 32'(NSETS);
  assign tag_bits         = 32'(TAG_W);

  logic [SEC_IW-1:0] sec_idx;
  logic [SET_IW-1:0] set_idx;
  logic [TAG_W-1:0]  tag;

  assign sec_idx = SEC_IW'((addr >> BYTE_W) & ADDR_W'(SPL - 1));
  assign set_idx = SET_IW'((addr >> OFF_W) & ADDR_W'(NSETS_I - 1));
  assign tag     = TAG_W'(addr >> (OFF_W + SET_W));

  logic             vld  [NSETS_I][WAYS];
  logic [TAG_W-1:0] tags [NSETS_I][WAYS];
  logic [SPL-1:0]   sect [NSETS_I][WAYS];

  logic              tag_hit;
  logic              sec_hit;
  logic              has_free;
  logic [WAY_IW-1:0] hit_way;
  logic [WAY_IW-1:0] free_way;
  logic [WAY_IW-1:0] victim;
  logic [WAY_IW-1:0] acc_way;
  logic [SPL-1:0]    sec_onehot;

  always_comb begin
    tag_hit  = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld[set_idx][w] && tags[set_idx][w] == tag) begin
        tag_hit = 1'b1;
        hit_way = WAY_IW'(w);
      end
    end
    // Descending scan leaves the lowest-numbered invalid way.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld[set_idx][w]) begin
        has_free = 1'b1;
        free_way = WAY_IW'(w);
      end
    end
  end

  assign sec_onehot = SPL'(1) << sec_idx;
  assign sec_hit    = tag_hit &&
                      ((sect[set_idx][hit_way] & sec_onehot) != '0);
  assign acc_way    = tag_hit  ? hit_way :
                      has_free ? free_way : victim;

  configurable_cache_lru #(
    .NUM_SETS (NSETS_I),
    .WAYS     (WAYS),
    .SET_IW   (SET_IW),
    .WAY_IW   (WAY_IW)
  ) u_lru (
    .clk     (clk),
    .rst     (rst),
    .set_idx (set_idx),
    .update  (1'b1),
    .way     (acc_way),
    .victim  (victim)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < NSETS_I; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          vld[s][w]  <= 1'b0;
          sect[s][w] <= '0;
        end
      end
      hit          <= 1'b0;
      miss         <= 1'b0;
      total_hits   <= '0;
      total_misses <= '0;
    end else begin
      hit  <= sec_hit;
      miss <= !sec_hit;
      if (sec_hit)
        total_hits <= total_hits + 32'd1;
      else
        total_misses <= total_misses + 32'd1;
      if (tag_hit) begin
        sect[set_idx][hit_way] <= sect[set_idx][hit_way] | sec_onehot;
      end else begin
        vld[set_idx][acc_way]  <= 1'b1;
        tags[set_idx][acc_way] <= tag;
        sect[set_idx][acc_way] <= sec_onehot;
      end
    end
  end

endmodule

// File: tb/tb_configurable_cache.sv
// Directed bench for configurable_cache at default geometry.
// Inputs change on the falling edge; outputs are checked one falling edge later.
module tb_configurable_cache;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        hit;
  logic        miss;
  logic [31:0] total_hits;
  logic [31:0] total_misses;
  logic [31:0] sectors_per_line;
  logic [31:0] num_sets;
  logic [31:0] tag_bits;

  int n_tests = 0;
  int n_fail  = 0;

  configurable_cache dut (
    .clk              (clk),
    .rst              (rst),
    .addr             (addr),
    .hit              (hit),
    .miss             (miss),
    .total_hits       (total_hits),
    .total_misses     (total_misses),
    .sectors_per_line (sectors_per_line),
    .num_sets         (num_sets),
    .tag_bits         (tag_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Called at a falling edge: present addr, check its result one cycle later.
  task automatic access(input logic [31:0] a, input bit exp_hit,
                        input string name);
    addr = a;
    @(negedge clk);
    check({name, ".hit"}, {31'd0, hit}, {31'd0, exp_hit});
    check({name, ".miss"}, {31'd0, miss}, {31'd0, !exp_hit});
  endtask

  task automatic check_consts(input string name);
    check({name, ".spl"}, sectors_per_line, 32'd8);
    check({name, ".sets"}, num_sets, 32'd8);
    check({name, ".tagb"}, tag_bits, 32'd24);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b0;
    addr = 32'h0;
    @(negedge clk);
    check_consts(name);
    check({name, ".hit"}, {31'd0, hit}, 32'd0);
    check({name, ".miss"}, {31'd0, miss}, 32'd0);
    check({name, ".th"}, total_hits, 32'd0);
    check({name, ".tm"}, total_misses, 32'd0);
    rst = 1'b1;
  endtask

  task automatic totals(input string name, input int h, input int m);
    check({name, ".th"}, total_hits, 32'(h));
    check({name, ".tm"}, total_misses, 32'(m));
  endtask

  initial begin
    rst  = 1'b0;
    addr = 32'h0;
    #1;
    check_consts("const_pre_edge");
    @(negedge clk);
    do_reset("rst0");
    check_consts("const_post");

    // Same address held: cold miss then back-to-back hits.
    access(32'h0, 1'b0, "rep0");
    access(32'h0, 1'b1, "rep1");
    access(32'h0, 1'b1, "rep2");
    access(32'h0, 1'b1, "rep3");
    totals("rep", 3, 1);

    // Sector miss on a present line, then sector hits.
    do_reset("rst1");
    access(32'h0, 1'b0, "sec0");
    access(32'h4, 1'b0, "sec4");
    access(32'h0, 1'b1, "sec0b");
    access(32'h4, 1'b1, "sec4b");
    access(32'h3, 1'b1, "sec3");
    access(32'h20, 1'b0, "set1");
    access(32'h3c, 1'b0, "set1s7");
    access(32'h38, 1'b0, "set1s6");
    access(32'h3f, 1'b1, "set1s7b");
    totals("sec", 4, 5);

    // Two lines in one set alternate without eviction.
    do_reset("rst2");
    for (int i = 0; i < 10; i++)
      access((i % 2 == 0) ? 32'h0 : 32'h100, i >= 2, $sformatf("alt%0d", i));
    totals("alt", 8, 2);

    // 33 distinct tags in set 0 overflow its 32 ways.
    do_reset("rst3");
    for (int k = 0; k <= 32; k++)
      access(32'(k) * 32'd256, 1'b0, $sformatf("fill%0d", k));
    access(32'h0, 1'b0, "evict0");
    access(32'h2000, 1'b1, "keep32");
    access(32'h100, 1'b0, "evict1");
    access(32'h300, 1'b1, "keep3");
    totals("lru", 2, 35);

    // Mid-run reset discards contents.
    access(32'h0, 1'b1, "pre_rst");
    do_reset("rst4");
    access(32'h0, 1'b0, "post_rst");
    totals("post_rst", 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
